data_ram_arbiter: RTL and testbench

- Two-master arbiter placed between the CPU data port and data_ram in the min SOPC.
- Master 0 is the CPU load/store port; master 1 is a loader/DMA port used to preload or inspect data memory.
- Grants at most one RAM access per cycle, returns read data to the owning master one cycle later, and generates a CPU stall while the CPU waits.
- Supports locked bursts for master 1, bounded by a burst limit so the CPU cannot starve.

---
 rtl/data_ram_arbiter.sv | 129 ++++++++++++
 tb/tb_data_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter in front of the SOPC data RAM: CPU port (m0) and loader/DMA port (m1).
// One RAM access per cycle, read data returned to its owner one cycle after issue.
module data_ram_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_sel,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_stall,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_sel,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    typedef enum logic {IDLE, LOCK} state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_owner_q, resp_owner_d;
    logic        gnt0, gnt1;
    logic        lock_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            burst_cnt_q  <= 8'd0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    // Grant decision; outputs are held at zero while reset is asserted.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        lock_ok = (state_q == LOCK) && (burst_cnt_q < MAX_B);
        if (rst) begin
            if (lock_ok && m1_req && m1_lock) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                // Leaving a lock (or forced yield) always favours the CPU.
                if (state_q == LOCK || last_grant_q) gnt0 = 1'b1;
                else                                 gnt1 = 1'b1;
            end else if (m0_req) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = IDLE;
        last_grant_d = last_grant_q;
        burst_cnt_d  = 8'd0;
        resp_valid_d = 1'b0;
        resp_owner_d = resp_owner_q;
        if (gnt0 || gnt1) begin
            last_grant_d = gnt1;
            resp_valid_d = gnt1 ? ~m1_we : ~m0_we;
            resp_owner_d = gnt1;
            if (gnt1 && m1_lock) begin
                state_d     = LOCK;
                // A grant taken after a forced yield starts a fresh burst.
                burst_cnt_d = lock_ok ? burst_cnt_q + 8'd1 : 8'd1;
            end
        end
    end

    always_comb begin
        ram_ce     = gnt0 | gnt1;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_sel    = 4'h0;
        ram_data_o = '0;
        if (gnt0) begin
            ram_we     = m0_we;
            ram_addr   = m0_addr;
            ram_sel    = m0_sel;
            ram_data_o = m0_wdata;
        end else if (gnt1) begin
            ram_we     = m1_we;
            ram_addr   = m1_addr;
            ram_sel    = m1_sel;
            ram_data_o = m1_wdata;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_stall  = rst & m0_req & ~gnt0;
    assign m0_rvalid = resp_valid_q & ~resp_owner_q;
    assign m1_rvalid = resp_valid_q &  resp_owner_q;
    assign m0_rdata  = m0_rvalid ? ram_data_i : '0;
    assign m1_rdata  = m1_rvalid ? ram_data_i : '0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a small byte-lane RAM model behind it.
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_gnt, m0_stall, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_data_o, ram_data_i;
    logic [3:0]  ram_sel;
    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
    );

    function automatic logic [31:0] init_word(input int idx);
        return idx * 32'h0101_0101;
    endfunction

    // RAM model: synchronous read, data valid the cycle after issue.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (ram_ce) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
            end else begin
                ram_data_i <= mem[ram_addr[9:2]];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_sel = 4'hF; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_sel = 4'hF; m1_wdata = 0; m1_lock = 0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_m1;
        m0_req = 1; m0_addr = 32'h20; m1_req = 1; m1_addr = 32'h24;
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt, m0_stall, m0_rvalid, m1_rvalid, ram_ce, ram_we} !== 7'd0 ||
            ram_addr !== 0 || ram_data_o !== 0 || ram_sel !== 0 || m0_rdata !== 0 || m1_rdata !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b/%b stall=%b rvalid=%b/%b ce=%b addr=%h required all zero",
                     m0_gnt, m1_gnt, m0_stall, m0_rvalid, m1_rvalid, ram_ce, ram_addr);
        end
        cyc();
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_m1 = (i % 2 == 1) ? 32'd1 : 32'd0;
            n_checks++;
            if (m1_gnt !== exp_m1[0] || m0_gnt !== ~exp_m1[0]) begin
                n_fail++;
                $display("FAIL rr_alternate[%0d]: m0_gnt=%b m1_gnt=%b required m0=%b m1=%b",
                         i, m0_gnt, m1_gnt, ~exp_m1[0], exp_m1[0]);
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_sel = 4'hF; m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1 || ram_ce !== 1 || ram_we !== 1 || ram_addr !== 32'h10 ||
            ram_sel !== 4'hF || ram_data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL m0_write_issue: gnt=%b ce=%b we=%b addr=%h sel=%h data=%h required 1 1 1 10 f deadbeef",
                     m0_gnt, ram_ce, ram_we, ram_addr, ram_sel, ram_data_o);
        end
        cyc();
        m0_we = 0; m0_wdata = 0;
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1 || ram_ce !== 1 || ram_we !== 0 || m0_rvalid !== 0) begin
            n_fail++;
            $display("FAIL m0_read_issue: gnt=%b ce=%b we=%b rvalid=%b required 1 1 0 0",
                     m0_gnt, ram_ce, ram_we, m0_rvalid);
        end
        cyc();
        m0_req = 0;
        @(negedge clk);
        n_checks++;
        if (m0_rvalid !== 1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 0 || m1_rdata !== 0) begin
            n_fail++;
            $display("FAIL m0_read_data: rvalid=%b rdata=%h m1_rvalid=%b m1_rdata=%h required 1 deadbeef 0 0",
                     m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
        end
        cyc();
        m1_req = 1; m1_we = 1; m1_addr = 32'h10; m1_sel = 4'h3; m1_wdata = 32'h0000_1234;
        @(negedge clk);
        n_checks++;
        if (m1_gnt !== 1 || m0_gnt !== 0 || ram_sel !== 4'h3 || ram_we !== 1 || m0_rvalid !== 0) begin
            n_fail++;
            $display("FAIL m1_write_issue: m1_gnt=%b m0_gnt=%b sel=%h we=%b m0_rvalid=%b required 1 0 3 1 0",
                     m1_gnt, m0_gnt, ram_sel, ram_we, m0_rvalid);
        end
        cyc();
        m1_we = 0; m1_sel = 4'hF; m1_wdata = 0;
        cyc();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (m1_rvalid !== 1 || m1_rdata !== 32'hDEAD1234 || m0_rvalid !== 0 || m0_rdata !== 0) begin
            n_fail++;
            $display("FAIL m1_read_data: rvalid=%b rdata=%h m0_rvalid=%b m0_rdata=%h required 1 dead1234 0 0",
                     m1_rvalid, m1_rdata, m0_rvalid, m0_rdata);
        end
        cyc();
    endtask

    task automatic test_single_read();
        m0_req = 1; m0_addr = 32'h10;
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1 || m0_stall !== 0 || m0_rvalid !== 0) begin
            n_fail++;
            $display("FAIL single_issue: gnt=%b stall=%b rvalid=%b required 1 0 0", m0_gnt, m0_stall, m0_rvalid);
        end
        cyc();
        m0_req = 0;
        @(negedge clk);
        n_checks++;
        if (m0_rvalid !== 1 || m0_rdata !== 32'hDEAD1234 || m0_stall !== 0) begin
            n_fail++;
            $display("FAIL single_latency: rvalid=%b rdata=%h stall=%b required 1 dead1234 0",
                     m0_rvalid, m0_rdata, m0_stall);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (m0_rvalid !== 0) begin
            n_fail++;
            $display("FAIL single_rvalid_once: rvalid=%b required 0", m0_rvalid);
        end
        cyc();
    endtask

    task automatic test_burst_yield();
        logic exp_m1, exp_stall;
        int   m1_grants = 0;
        m0_req = 1; m0_addr = 32'h100;
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1) begin
            n_fail++;
            $display("FAIL yield_setup: m0_gnt=%b required 1", m0_gnt);
        end
        cyc();
        m1_req = 1; m1_lock = 1;
        for (int c = 0; c < 13; c++) begin
            m1_addr = 32'h100 + 4 * m1_grants;
            exp_m1    = (c != 8);
            exp_stall = (c < 8);
            @(negedge clk);
            n_checks++;
            if (m1_gnt !== exp_m1 || m0_gnt !== (c == 8) || m0_stall !== exp_stall) begin
                n_fail++;
                $display("FAIL burst_yield[%0d]: m1_gnt=%b m0_gnt=%b stall=%b required %b %b %b",
                         c, m1_gnt, m0_gnt, m0_stall, exp_m1, (c == 8), exp_stall);
            end
            if (m1_gnt) m1_grants++;
            cyc();
            if (c == 8) m0_req = 0;
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_burst_no_contention();
        logic [7:0] exp_cnt;
        m1_req = 1; m1_lock = 1;
        for (int i = 0; i < 20; i++) begin
            m1_addr = 32'h100 + 4 * i;
            @(negedge clk);
            n_checks++;
            if (m1_gnt !== 1 || m0_gnt !== 0 || m0_stall !== 0) begin
                n_fail++;
                $display("FAIL solo_burst_gnt[%0d]: m1_gnt=%b m0_gnt=%b stall=%b required 1 0 0",
                         i, m1_gnt, m0_gnt, m0_stall);
            end
            if (i > 0) begin
                n_checks++;
                if (m1_rvalid !== 1 || m1_rdata !== init_word(64 + i - 1)) begin
                    n_fail++;
                    $display("FAIL solo_burst_data[%0d]: rvalid=%b rdata=%h required 1 %h",
                             i, m1_rvalid, m1_rdata, init_word(64 + i - 1));
                end
            end
            cyc();
            exp_cnt = 8'((i % 8) + 1);
            n_checks++;
            if (dut.burst_cnt_q !== exp_cnt) begin
                n_fail++;
                $display("FAIL burst_cnt[%0d]: got %0d required %0d", i, dut.burst_cnt_q, exp_cnt);
            end
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (m1_rvalid !== 1 || m1_rdata !== init_word(64 + 19)) begin
            n_fail++;
            $display("FAIL solo_burst_last: rvalid=%b rdata=%h required 1 %h", m1_rvalid, m1_rdata, init_word(83));
        end
        cyc();
        n_checks++;
        if (dut.burst_cnt_q !== 8'd0) begin
            n_fail++;
            $display("FAIL burst_cnt_clear: got %0d required 0", dut.burst_cnt_q);
        end
    endtask

    task automatic test_reset_inflight();
        m0_req = 1; m0_addr = 32'h10;
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1) begin
            n_fail++;
            $display("FAIL inflight_issue: m0_gnt=%b required 1", m0_gnt);
        end
        cyc();
        rst = 0;
        m0_we = 1; m0_addr = 32'h200; m1_req = 1; m1_we = 1; m1_addr = 32'h204; m1_lock = 1;
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt, m0_stall, m0_rvalid, m1_rvalid, ram_ce, ram_we} !== 7'd0 ||
            m0_rdata !== 0 || m1_rdata !== 0 || ram_addr !== 0) begin
            n_fail++;
            $display("FAIL inflight_drop: gnt=%b/%b stall=%b rvalid=%b/%b ce=%b rdata=%h required all zero",
                     m0_gnt, m1_gnt, m0_stall, m0_rvalid, m1_rvalid, ram_ce, m0_rdata);
        end
        cyc();
        cyc();
        rst = 1;
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1 || m1_gnt !== 0) begin
            n_fail++;
            $display("FAIL post_reset_first: m0_gnt=%b m1_gnt=%b required 1 0", m0_gnt, m1_gnt);
        end
        cyc();
        m0_req = 0;
        @(negedge clk);
        n_checks++;
        if (m0_rvalid !== 0 || m1_rvalid !== 0 || m1_gnt !== 1) begin
            n_fail++;
            $display("FAIL post_reset_second: m0_rvalid=%b m1_rvalid=%b m1_gnt=%b required 0 0 1",
                     m0_rvalid, m1_rvalid, m1_gnt);
        end
        cyc();
        idle_inputs();
        cyc();
    endtask

    initial begin
        rst = 0;
        ram_data_i = 0;
        idle_inputs();
        repeat (3) cyc();
        test_reset();
        test_write_read();
        test_single_read();
        test_burst_yield();
        test_burst_no_contention();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
